// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns engine: one 128-bit state in, forward or inverse mix,
// COLS_PER_CYCLE columns per clock, valid/ready handshake on both sides.
module mix_columns_iter #(
   parameter int unsigned COLS_PER_CYCLE = 1,
   parameter logic [8:0]  GF_POLY        = 9'h11B
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_inv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e               state_q;
   logic [1:0]           k_q;
   logic                 inv_q;
   logic [3:0][31:0]     work_q;
   logic [3:0][31:0]     work_d;
   logic [127:0]         res_q;
   logic                 in_ready_q;
   logic                 out_valid_q;
   logic                 busy_q;
   logic [1:0]           col_idx;
   logic                 last_group;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY[7:0] : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
      logic [3:0][7:0] s, x2, x4, x8, o;
      logic [1:0]      r0, r1, r2, r3;
      s = col;
      for (int i = 0; i < 4; i++) begin
         r0     = 2'(i);
         x2[r0] = xtime(s[r0]);
         x4[r0] = xtime(x2[r0]);
         x8[r0] = xtime(x4[r0]);
      end
      for (int i = 0; i < 4; i++) begin
         r0 = 2'(i);
         r1 = r0 + 2'd1;
         r2 = r0 + 2'd2;
         r3 = r0 + 2'd3;
         if (inv) begin
            // 0e, 0b, 0d, 09 built from the x2/x4/x8 chain
            o[r0] = (x8[r0] ^ x4[r0] ^ x2[r0]) ^ (x8[r1] ^ x2[r1] ^ s[r1]) ^
                    (x8[r2] ^ x4[r2] ^ s[r2]) ^ (x8[r3] ^ s[r3]);
         end else begin
            o[r0] = x2[r0] ^ (x2[r1] ^ s[r1]) ^ s[r2] ^ s[r3];
         end
      end
      return o;
   endfunction

   always_comb begin
      work_d  = work_q;
      col_idx = k_q;
      for (int g = 0; g < int'(COLS_PER_CYCLE); g++) begin
         col_idx         = k_q + 2'(g);
         work_d[col_idx] = mix_col(work_q[col_idx], inv_q);
      end
      last_group = (k_q == 2'(4 - COLS_PER_CYCLE));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         k_q         <= 2'd0;
         inv_q       <= 1'b0;
         work_q      <= '0;
         res_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  work_q     <= in_data;
                  inv_q      <= in_inv;
                  k_q        <= 2'd0;
                  state_q    <= StBusy;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            StBusy: begin
               work_q <= work_d;
               k_q    <= k_q + 2'(COLS_PER_CYCLE);
               if (last_group) begin
                  // result register keeps the last answer visible after the handshake
                  res_q       <= work_d;
                  state_q     <= StDone;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end
            end
            StDone: begin
               if (out_ready) begin
                  state_q     <= StIdle;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= StIdle;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = res_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: three instances (1, 2, 4 columns per clock) checked
// against a matrix-multiply GF(2^8) reference model.
module tb_mix_columns_iter;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid_a  [3];
   logic         in_ready_a  [3];
   logic [127:0] in_data_a   [3];
   logic         in_inv_a    [3];
   logic         out_valid_a [3];
   logic         out_ready_a [3];
   logic [127:0] out_data_a  [3];
   logic         busy_a      [3];

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mix_columns_iter #(.COLS_PER_CYCLE(1)) u_c1 (
      .clk(clk), .rst(rst), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
      .in_data(in_data_a[0]), .in_inv(in_inv_a[0]), .out_valid(out_valid_a[0]),
      .out_ready(out_ready_a[0]), .out_data(out_data_a[0]), .busy(busy_a[0]));
   mix_columns_iter #(.COLS_PER_CYCLE(2)) u_c2 (
      .clk(clk), .rst(rst), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
      .in_data(in_data_a[1]), .in_inv(in_inv_a[1]), .out_valid(out_valid_a[1]),
      .out_ready(out_ready_a[1]), .out_data(out_data_a[1]), .busy(busy_a[1]));
   mix_columns_iter #(.COLS_PER_CYCLE(4)) u_c4 (
      .clk(clk), .rst(rst), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
      .in_data(in_data_a[2]), .in_inv(in_inv_a[2]), .out_valid(out_valid_a[2]),
      .out_ready(out_ready_a[2]), .out_data(out_data_a[2]), .busy(busy_a[2]));

   function automatic int exp_lat(input int d);
      return (d == 0) ? 4 : (d == 1) ? 2 : 1;
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
      return p[7:0];
   endfunction

   // out[r] = sum_j coef[(j - r) mod 4] * s[j], coef = first matrix row
   function automatic logic [127:0] ref_mix(input logic [127:0] st, input logic inv);
      logic [7:0]   cf [4];
      logic [127:0] res;
      logic [7:0]   acc;
      if (inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
      res = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gmul(cf[(j - r + 4) % 4], st[32*c + 8*j +: 8]);
            res[32*c + 8*r +: 8] = acc;
         end
      return res;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one block through instance d; returns observations only.
   task automatic run_block(input int d, input logic [127:0] data, input logic inv,
                            input int pre_gap, input int rdy_delay,
                            output logic [127:0] res, output int lat,
                            output bit rdy_low, output bit dup, output bit to);
      int w;
      to = 0; rdy_low = 1; dup = 0; lat = 0; res = '0; w = 0;
      repeat (pre_gap) tick();
      while (!in_ready_a[d] && w < 50) begin tick(); w++; end
      if (!in_ready_a[d]) begin to = 1; return; end
      in_data_a[d] = data; in_inv_a[d] = inv; in_valid_a[d] = 1'b1;
      tick();
      in_valid_a[d] = 1'b0; in_data_a[d] = rnd128(); in_inv_a[d] = ~inv;
      if (in_ready_a[d]) rdy_low = 0;
      while (!out_valid_a[d] && lat < 20) begin
         tick(); lat++;
         if (in_ready_a[d]) rdy_low = 0;
      end
      if (!out_valid_a[d]) begin to = 1; return; end
      repeat (rdy_delay) begin tick(); if (in_ready_a[d]) rdy_low = 0; end
      res = out_data_a[d];
      out_ready_a[d] = 1'b1;
      tick();
      out_ready_a[d] = 1'b0;
      dup = out_valid_a[d];
   endtask

   task automatic test_reset();
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      for (int d = 0; d < 3; d++) begin
         n_vec++; if (out_valid_a[d] !== 1'b0) begin n_fail++;
            $display("FAIL reset_out_valid d=%0d got %b want 0", d, out_valid_a[d]); end
         n_vec++; if (out_data_a[d] !== 128'h0) begin n_fail++;
            $display("FAIL reset_out_data d=%0d got %h want 0", d, out_data_a[d]); end
         n_vec++; if (in_ready_a[d] !== 1'b1) begin n_fail++;
            $display("FAIL reset_in_ready d=%0d got %b want 1", d, in_ready_a[d]); end
         n_vec++; if (busy_a[d] !== 1'b0) begin n_fail++;
            $display("FAIL reset_busy d=%0d got %b want 0", d, busy_a[d]); end
      end
   endtask

   task automatic test_forward();
      logic [127:0] res; int lat; bit rl, dup, to;
      run_block(0, 128'hC6C6C6C6_01010101_5C220AF2_455313DB, 1'b0, 0, 0, res, lat, rl, dup, to);
      n_vec++; if (to || res !== 128'hC6C6C6C6_01010101_9D58DC9F_BCA14D8E) begin n_fail++;
         $display("FAIL fwd_vector got %h (to=%0b) want %h", res, to,
                  128'hC6C6C6C6_01010101_9D58DC9F_BCA14D8E); end
      n_vec++; if (lat !== 4) begin n_fail++;
         $display("FAIL fwd_latency got %0d want 4", lat); end
   endtask

   task automatic test_inverse_roundtrip();
      logic [127:0] res; int lat; bit rl, dup, to;
      run_block(0, 128'hC6C6C6C6_01010101_9D58DC9F_BCA14D8E, 1'b1, 0, 0, res, lat, rl, dup, to);
      n_vec++; if (to || res !== 128'hC6C6C6C6_01010101_5C220AF2_455313DB) begin n_fail++;
         $display("FAIL inv_vector1 got %h want %h", res,
                  128'hC6C6C6C6_01010101_5C220AF2_455313DB); end
      run_block(0, 128'h01010101_C6C6C6C6_4C31262D_D5D4D4D4, 1'b0, 1, 1, res, lat, rl, dup, to);
      n_vec++; if (to || res !== 128'h01010101_C6C6C6C6_F8BD7E4D_D6D7D5D5) begin n_fail++;
         $display("FAIL fwd_vector2 got %h want %h", res,
                  128'h01010101_C6C6C6C6_F8BD7E4D_D6D7D5D5); end
      run_block(0, 128'h01010101_C6C6C6C6_F8BD7E4D_D6D7D5D5, 1'b1, 0, 2, res, lat, rl, dup, to);
      n_vec++; if (to || res !== 128'h01010101_C6C6C6C6_4C31262D_D5D4D4D4) begin n_fail++;
         $display("FAIL inv_vector2 got %h want %h", res,
                  128'h01010101_C6C6C6C6_4C31262D_D5D4D4D4); end
   endtask

   task automatic test_param_sweep();
      logic [127:0] res; int lat; bit rl, dup, to;
      for (int d = 1; d < 3; d++) begin
         run_block(d, 128'hC6C6C6C6_01010101_5C220AF2_455313DB, 1'b0, 0, 1,
                   res, lat, rl, dup, to);
         n_vec++; if (to || res !== 128'hC6C6C6C6_01010101_9D58DC9F_BCA14D8E) begin n_fail++;
            $display("FAIL sweep_data d=%0d got %h want %h", d, res,
                     128'hC6C6C6C6_01010101_9D58DC9F_BCA14D8E); end
         n_vec++; if (lat !== exp_lat(d)) begin n_fail++;
            $display("FAIL sweep_latency d=%0d got %0d want %0d", d, lat, exp_lat(d)); end
         n_vec++; if (rl !== 1'b1) begin n_fail++;
            $display("FAIL sweep_in_ready_low d=%0d got %b want 1", d, rl); end
         n_vec++; if (in_ready_a[d] !== 1'b1) begin n_fail++;
            $display("FAIL sweep_in_ready_after d=%0d got %b want 1", d, in_ready_a[d]); end
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] v1, v2, e1; int w;
      v1 = rnd128(); e1 = ref_mix(v1, 1'b0); v2 = rnd128(); w = 0;
      in_data_a[0] = v1; in_inv_a[0] = 1'b0; in_valid_a[0] = 1'b1;
      tick();
      in_valid_a[0] = 1'b0;
      while (!out_valid_a[0] && w < 20) begin tick(); w++; end
      for (int i = 0; i < 10; i++) begin
         tick();
         n_vec++; if (out_valid_a[0] !== 1'b1 || out_data_a[0] !== e1) begin n_fail++;
            $display("FAIL bp_hold cyc=%0d got v=%b %h want v=1 %h", i, out_valid_a[0],
                     out_data_a[0], e1); end
         n_vec++; if (in_ready_a[0] !== 1'b0) begin n_fail++;
            $display("FAIL bp_in_ready cyc=%0d got %b want 0", i, in_ready_a[0]); end
      end
      out_ready_a[0] = 1'b1; in_valid_a[0] = 1'b1; in_data_a[0] = v2; in_inv_a[0] = 1'b1;
      tick();
      out_ready_a[0] = 1'b0;
      n_vec++; if (out_valid_a[0] !== 1'b0 || busy_a[0] !== 1'b0 || in_ready_a[0] !== 1'b1)
         begin n_fail++;
         $display("FAIL bp_consume got v=%b busy=%b rdy=%b want 0 0 1", out_valid_a[0],
                  busy_a[0], in_ready_a[0]); end
      tick();
      in_valid_a[0] = 1'b0;
      n_vec++; if (busy_a[0] !== 1'b1 || in_ready_a[0] !== 1'b0) begin n_fail++;
         $display("FAIL bp_accept_next got busy=%b rdy=%b want 1 0", busy_a[0], in_ready_a[0]);
      end
      w = 0;
      while (!out_valid_a[0] && w < 20) begin tick(); w++; end
      n_vec++; if (w !== 4 || out_data_a[0] !== ref_mix(v2, 1'b1)) begin n_fail++;
         $display("FAIL bp_second_block got lat=%0d %h want lat=4 %h", w, out_data_a[0],
                  ref_mix(v2, 1'b1)); end
      out_ready_a[0] = 1'b1; tick(); out_ready_a[0] = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [127:0] v, res; int lat, w; bit rl, dup, to;
      for (int phase = 0; phase < 2; phase++) begin
         v = rnd128(); w = 0;
         in_data_a[0] = v; in_inv_a[0] = phase[0]; in_valid_a[0] = 1'b1;
         tick();
         in_valid_a[0] = 1'b0;
         if (phase == 0) begin
            tick(); tick();
            n_vec++; if (busy_a[0] !== 1'b1) begin n_fail++;
               $display("FAIL rst_mid_busy_before got %b want 1", busy_a[0]); end
         end else begin
            while (!out_valid_a[0] && w < 20) begin tick(); w++; end
            n_vec++; if (out_valid_a[0] !== 1'b1) begin n_fail++;
               $display("FAIL rst_done_valid_before got %b want 1", out_valid_a[0]); end
         end
         rst = 1'b1; tick(); rst = 1'b0;
         n_vec++; if (out_valid_a[0] !== 1'b0 || out_data_a[0] !== 128'h0 ||
                      in_ready_a[0] !== 1'b1 || busy_a[0] !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid phase=%0d got v=%b d=%h rdy=%b busy=%b want 0 0 1 0", phase,
                     out_valid_a[0], out_data_a[0], in_ready_a[0], busy_a[0]); end
         v = rnd128();
         run_block(0, v, 1'b0, 0, 0, res, lat, rl, dup, to);
         n_vec++; if (to || res !== ref_mix(v, 1'b0) || lat !== 4) begin n_fail++;
            $display("FAIL rst_mid_after phase=%0d got %h lat=%0d want %h lat=4", phase, res,
                     lat, ref_mix(v, 1'b0)); end
      end
   endtask

   task automatic test_random();
      logic [127:0] v, res; logic inv; int lat, n; bit rl, dup, to;
      for (int d = 0; d < 3; d++) begin
         n = (d == 0) ? 600 : 200;
         for (int i = 0; i < n; i++) begin
            v = rnd128(); inv = 1'($urandom_range(0, 1));
            run_block(d, v, inv, $urandom_range(0, 3), $urandom_range(0, 3),
                      res, lat, rl, dup, to);
            n_vec++; if (to || res !== ref_mix(v, inv)) begin n_fail++;
               $display("FAIL rand_data d=%0d i=%0d inv=%b got %h (to=%0b) want %h", d, i, inv,
                        res, to, ref_mix(v, inv)); end
            n_vec++; if (lat !== exp_lat(d) || rl !== 1'b1 || dup !== 1'b0) begin n_fail++;
               $display("FAIL rand_flow d=%0d i=%0d got lat=%0d rdylow=%b dup=%b want %0d 1 0",
                        d, i, lat, rl, dup, exp_lat(d)); end
         end
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 3; d++) begin
         in_valid_a[d] = 1'b0; in_data_a[d] = '0; in_inv_a[d] = 1'b0; out_ready_a[d] = 1'b0;
      end
      #1;
      test_reset();
      test_forward();
      test_inverse_roundtrip();
      test_param_sweep();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/mix_columns_iter.md
Name: mix_columns_iter

Overview:
- Iterative, handshaked AES MixColumns engine, the parametrised successor of the combinational column mixer.
- Supports forward and inverse MixColumns, selected per block.
- Throughput/area trade-off through a configurable number of columns processed per clock.
- Sits between ShiftRows and AddRoundKey in the round datapath; accepts one 128-bit state and returns one 128-bit state.

Parameters:
- COLS_PER_CYCLE, 1, columns mixed per clock; legal values 1, 2, 4. Any other value is an elaboration error.
- GF_POLY, 9'h11B, reduction polynomial for xtime; fixed for AES, exposed for verification only.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  in_data/in_inv are valid.
- in_ready  output  1  block can accept a state.
- in_data  input  128  state; column c = bits [32c +: 32], row r of column c = bits [32c+8r +: 8].
- in_inv  input  1  0 = forward MixColumns, 1 = inverse; sampled at accept.
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  128  mixed state, same byte layout as in_data.
- busy  output  1  high in the BUSY state.

Behaviour:
- Reset: synchronous, active-high. On any rising edge with rst=1:
  - state goes to IDLE and the column counter to 0;
  - out_valid=0, out_data=0, busy=0, in_ready=1 on the following cycle;
  - any in-flight block is discarded, including one already in DONE.
- FSM states and transitions:
  - IDLE: in_ready=1. in_valid=1 moves to BUSY; in_data is captured into the working register, in_inv into the mode register, counter k=0.
  - BUSY: in_ready=0, busy=1. Each cycle columns k..k+COLS_PER_CYCLE-1 are mixed and written back in place, and k advances by COLS_PER_CYCLE. When the last group is written, the state moves to DONE.
  - DONE: out_valid=1 and out_data = working register, held stable until out_ready=1. On out_valid&out_ready the state moves to IDLE.
- Latency:
  - N = 4/COLS_PER_CYCLE BUSY cycles; out_valid rises N clocks after the accept edge (4, 2 or 1).
  - Throughput is one block per N+2 cycles.
  - No overlap between blocks: in_ready is 0 in DONE, and accept happens only in IDLE.
- Arithmetic, per column, with bytes s0..s3 from rows 0..3:
  - Forward matrix rows: [02 03 01 01], [01 02 03 01], [01 01 02 03], [03 01 01 02].
  - Inverse matrix rows: [0e 0b 0d 09], [09 0e 0b 0d], [0d 09 0e 0b], [0b 0d 09 0e].
  - Multiplication is in GF(2^8): xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 0); higher constants are formed from xtime chains and XOR. All addition is XOR. Widths are strictly 8-bit.
- Mode and inputs:
  - The mode is fixed for the whole block. Changes to in_inv or in_data after accept have no effect.
  - in_valid while not IDLE is ignored; the upstream holds it.
- Output:
  - out_data in IDLE/BUSY holds the last completed result (0 after reset). It is qualified by out_valid only.
  - out_ready while out_valid=0 has no effect.
  - out_valid&out_ready and a new in_valid in the same cycle: the result is consumed and the state goes to IDLE. The new block is accepted on the next cycle, not in the same one.

Test Plan:
- Forward, COLS_PER_CYCLE=1:
  - in_data column 0 = 32'h455313DB, columns 1..3 = 32'h5C220AF2, 32'h01010101, 32'hC6C6C6C6 -> columns 32'hBCA14D8E, 32'h9D58DC9F, 32'h01010101, 32'hC6C6C6C6.
  - out_valid rises exactly 4 cycles after accept.
- Inverse round trip: feed the previous expected output with in_inv=1 -> the original input is returned. Repeat with columns 32'hD5D4D4D4 <-> 32'hD6D7D5D5 and 32'h4C31262D <-> 32'hF8BD7E4D.
- Parameter sweep: COLS_PER_CYCLE=2 and 4 with the first vector -> identical data; latency 2 and 1 cycles; in_ready low from accept until the cycle after the output handshake.
- Backpressure:
  - out_ready held 0 for 10 cycles -> out_valid and out_data stable, in_ready=0.
  - out_ready then pulses with in_valid=1 -> the new block is accepted one cycle later.
- Reset mid-operation: rst=1 during BUSY (k=2) and, separately, during DONE -> next cycle out_valid=0, out_data=0, in_ready=1. A following block produces the correct result.
- Random: 1000 random states with random in_inv, random in_valid/out_ready gaps, compared against a reference model -> zero mismatches, no dropped or duplicated blocks.
